// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder
//
// Turns a stream of PS/2 set-2 scan-code bytes into keyboard events. A prefix
// FSM strips E0 (extended) and F0 (break) prefixes and swallows the 8-byte
// Pause/Break (E1) sequence. Left/right shift and caps-lock state are tracked
// and used to translate each event into ASCII. Events are queued in a small
// first-word-fall-through FIFO.
//
// Ports
//   clk          system clock, all state on its rising edge
//   rst          asynchronous active-high reset
//   rx_done_tick one-cycle strobe, rx_dout holds a received byte
//   rx_dout      received scan-code byte
//   ev_ready     consumer accepts the head event
//   ev_valid     FIFO non-empty, head event presented on ev_*
//   ev_code      head event scan code with prefixes stripped
//   ev_ext       head event was E0-prefixed
//   ev_break     head event is a key release
//   ev_ascii     head event ASCII, 0x00 if unmapped
//   fifo_count   number of stored events (0..FIFO_DEPTH)
//   overflow     sticky flag, an event was dropped because the FIFO was full
//   shift_active left or right shift currently held
//   caps_lock    caps-lock toggle state

module ps2_kbd_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_done_tick,
    input  logic [7:0]                    rx_dout,
    input  logic                          ev_ready,
    output logic                          ev_valid,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_break,
    output logic [7:0]                    ev_ascii,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          shift_active,
    output logic                          caps_lock
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = 18;   // {code, ext, brk, ascii}

    typedef enum logic [2:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0,
        SKIP_E1
    } state_t;

    // ------------------------------------------------------------------
    // Scan-code to ASCII helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] letter_of(input logic [7:0] c);
        case (c)
            8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63;
            8'h23: return 8'h64; 8'h24: return 8'h65; 8'h2B: return 8'h66;
            8'h34: return 8'h67; 8'h33: return 8'h68; 8'h43: return 8'h69;
            8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
            8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F;
            8'h4D: return 8'h70; 8'h15: return 8'h71; 8'h2D: return 8'h72;
            8'h1B: return 8'h73; 8'h2C: return 8'h74; 8'h3C: return 8'h75;
            8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
            8'h35: return 8'h79; 8'h1A: return 8'h7A;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] other_of(input logic [7:0] c);
        case (c)
            8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32;
            8'h26: return 8'h33; 8'h25: return 8'h34; 8'h2E: return 8'h35;
            8'h36: return 8'h36; 8'h3D: return 8'h37; 8'h3E: return 8'h38;
            8'h46: return 8'h39;
            8'h29: return 8'h20;
            8'h5A: return 8'h0D;
            8'h66: return 8'h08;
            default: return 8'h00;
        endcase
    endfunction

    // Link-level bytes (BAT result, echo, ack, errors, resend) that carry no
    // key information when they arrive outside a prefix sequence.
    function automatic logic is_discard(input logic [7:0] c);
        case (c)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_reg, state_next;
    logic [2:0]         skip_cnt_reg, skip_cnt_next;
    logic               lshift_reg, lshift_next;
    logic               rshift_reg, rshift_next;
    logic               caps_reg, caps_next;
    logic               caps_held_reg, caps_held_next;
    logic               overflow_reg, overflow_next;

    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [WORD_W-1:0]  mem [FIFO_DEPTH];

    logic               push_req;
    logic               push_ext;
    logic               push_brk;
    logic [7:0]         push_ascii;
    logic               upper;
    logic [7:0]         letter;
    logic               fifo_full;
    logic               pop;
    logic               push_ok;
    logic [WORD_W-1:0]  head_word;

    // ------------------------------------------------------------------
    // Prefix FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        skip_cnt_next = skip_cnt_reg;
        push_req      = 1'b0;
        push_ext      = 1'b0;
        push_brk      = 1'b0;
        if (rx_done_tick) begin
            case (state_reg)
                IDLE: begin
                    if (rx_dout == 8'hE0) begin
                        state_next = GOT_E0;
                    end else if (rx_dout == 8'hF0) begin
                        state_next = GOT_F0;
                    end else if (rx_dout == 8'hE1) begin
                        push_req      = 1'b1;
                        state_next    = SKIP_E1;
                        skip_cnt_next = 3'd0;
                    end else if (!is_discard(rx_dout)) begin
                        push_req = 1'b1;
                    end
                end
                GOT_E0: begin
                    if (rx_dout == 8'hF0) begin
                        state_next = GOT_E0F0;
                    end else if (rx_dout != 8'hE0) begin
                        push_req   = 1'b1;
                        push_ext   = 1'b1;
                        state_next = IDLE;
                    end
                end
                GOT_F0: begin
                    if (rx_dout != 8'hE0 && rx_dout != 8'hF0) begin
                        push_req   = 1'b1;
                        push_brk   = 1'b1;
                        state_next = IDLE;
                    end
                end
                GOT_E0F0: begin
                    if (rx_dout != 8'hE0 && rx_dout != 8'hF0) begin
                        push_req   = 1'b1;
                        push_ext   = 1'b1;
                        push_brk   = 1'b1;
                        state_next = IDLE;
                    end
                end
                SKIP_E1: begin
                    // The Pause make sequence has seven bytes after the E1.
                    if (skip_cnt_reg == 3'd6) begin
                        skip_cnt_next = 3'd0;
                        state_next    = IDLE;
                    end else begin
                        skip_cnt_next = skip_cnt_reg + 3'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Modifier tracking and ASCII translation. ASCII uses the modifier
    // state before this byte's own update is applied.
    // ------------------------------------------------------------------
    assign upper  = (lshift_reg | rshift_reg) ^ caps_reg;
    assign letter = letter_of(rx_dout);

    always_comb begin
        push_ascii = 8'h00;
        if (!push_ext) begin
            if (letter != 8'h00) begin
                push_ascii = upper ? (letter - 8'h20) : letter;
            end else begin
                push_ascii = other_of(rx_dout);
            end
        end
    end

    always_comb begin
        lshift_next    = lshift_reg;
        rshift_next    = rshift_reg;
        caps_next      = caps_reg;
        caps_held_next = caps_held_reg;
        if (push_req && !push_ext) begin
            case (rx_dout)
                8'h12: lshift_next = !push_brk;
                8'h59: rshift_next = !push_brk;
                8'h58: begin
                    if (push_brk) begin
                        caps_held_next = 1'b0;
                    end else begin
                        // Typematic repeats arrive while the key is held and
                        // must not toggle again.
                        if (!caps_held_reg) begin
                            caps_next = !caps_reg;
                        end
                        caps_held_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    assign fifo_full = (count_reg == CNT_W'(FIFO_DEPTH));
    assign pop       = (count_reg != '0) && ev_ready;
    // A full FIFO still accepts a push in the cycle its head is popped.
    assign push_ok   = push_req && (!fifo_full || pop);

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        if (push_ok && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
        if (push_req && !push_ok) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wr_ptr_reg] <= {rx_dout, push_ext, push_brk, push_ascii};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            skip_cnt_reg  <= 3'd0;
            lshift_reg    <= 1'b0;
            rshift_reg    <= 1'b0;
            caps_reg      <= 1'b0;
            caps_held_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            skip_cnt_reg  <= skip_cnt_next;
            lshift_reg    <= lshift_next;
            rshift_reg    <= rshift_next;
            caps_reg      <= caps_next;
            caps_held_reg <= caps_held_next;
            overflow_reg  <= overflow_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The head word is masked while empty so the event outputs
    // read as zero after reset and between events.
    // ------------------------------------------------------------------
    assign head_word    = ev_valid ? mem[rd_ptr_reg] : '0;
    assign ev_valid     = (count_reg != '0);
    assign ev_code      = head_word[17:10];
    assign ev_ext       = head_word[9];
    assign ev_break     = head_word[8];
    assign ev_ascii     = head_word[7:0];
    assign fifo_count   = count_reg;
    assign overflow     = overflow_reg;
    assign shift_active = lshift_reg | rshift_reg;
    assign caps_lock    = caps_reg;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Testbench for ps2_kbd_decoder: a table of scan-code bytes with expected
// events and modifier state, followed by hand-written sequences for FIFO
// overflow/back-pressure and reset in the middle of a prefix.

module tb_ps2_kbd_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_dout = 8'h00;
    logic       ev_ready = 1'b1;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic [7:0] ev_ascii;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       shift_active;
    logic       caps_lock;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ps2_kbd_decoder #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_done_tick (rx_done_tick),
        .rx_dout      (rx_dout),
        .ev_ready     (ev_ready),
        .ev_valid     (ev_valid),
        .ev_code      (ev_code),
        .ev_ext       (ev_ext),
        .ev_break     (ev_break),
        .ev_ascii     (ev_ascii),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .shift_active (shift_active),
        .caps_lock    (caps_lock)
    );

    typedef struct {
        logic [7:0] b;
        logic       v;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] asc;
        logic       sh;
        logic       caps;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] b, input logic v,
                                input logic [7:0] code, input logic ext,
                                input logic brk, input logic [7:0] asc,
                                input logic sh, input logic caps);
        vec_t r;
        r.b = b; r.v = v; r.code = code; r.ext = ext; r.brk = brk;
        r.asc = asc; r.sh = sh; r.caps = caps;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One-cycle byte strobe; returns at the following falling edge, after
    // the byte has been consumed.
    task automatic tick(input logic [7:0] b);
        @(negedge clk);
        rx_dout      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    // Sends a byte with ev_ready=1 and checks the event it produces (or that
    // none appears), then that the event is gone one cycle later.
    task automatic send_chk(input string tag, input logic [7:0] b,
                            input logic v, input logic [7:0] code,
                            input logic ext, input logic brk,
                            input logic [7:0] asc);
        tick(b);
        $display("byte %h -> valid %0d code %h ext %0d brk %0d ascii %h",
                 b, ev_valid, ev_code, ev_ext, ev_break, ev_ascii);
        chk({tag, " valid"}, ev_valid, v);
        if (v) begin
            chk({tag, " code"}, ev_code, code);
            chk({tag, " ext"}, ev_ext, ext);
            chk({tag, " break"}, ev_break, brk);
            chk({tag, " ascii"}, ev_ascii, asc);
        end
        @(negedge clk);
        chk({tag, " valid one cycle"}, ev_valid, 1'b0);
    endtask

    logic [7:0] pop_exp [4];

    initial begin
        // ---------------- event table ----------------
        vecs.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 0, 0));
        vecs.push_back(mk(8'h12, 1, 8'h12, 0, 0, 8'h00, 1, 0));
        vecs.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 8'h41, 1, 0));
        vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 8'h00, 1, 0));
        vecs.push_back(mk(8'h1C, 1, 8'h1C, 0, 1, 8'h41, 1, 0));
        vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 8'h00, 1, 0));
        vecs.push_back(mk(8'h12, 1, 8'h12, 0, 1, 8'h00, 0, 0));
        vecs.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h75, 1, 8'h75, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h75, 1, 8'h75, 1, 1, 8'h00, 0, 0));
        vecs.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h12, 1, 8'h12, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h12, 1, 8'h12, 1, 1, 8'h00, 0, 0));
        vecs.push_back(mk(8'h58, 1, 8'h58, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(8'h58, 1, 8'h58, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(8'h58, 1, 8'h58, 0, 1, 8'h00, 0, 1));
        vecs.push_back(mk(8'h58, 1, 8'h58, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 0, 0));
        vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h58, 1, 8'h58, 0, 1, 8'h00, 0, 0));
        vecs.push_back(mk(8'h58, 1, 8'h58, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 8'h41, 0, 1));
        vecs.push_back(mk(8'h12, 1, 8'h12, 0, 0, 8'h00, 1, 1));
        vecs.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 1, 1));
        vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 8'h00, 1, 1));
        vecs.push_back(mk(8'h12, 1, 8'h12, 0, 1, 8'h00, 0, 1));
        vecs.push_back(mk(8'h45, 1, 8'h45, 0, 0, 8'h30, 0, 1));
        vecs.push_back(mk(8'h29, 1, 8'h29, 0, 0, 8'h20, 0, 1));
        vecs.push_back(mk(8'hAA, 0, 8'h00, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(8'h16, 1, 8'h16, 0, 0, 8'h31, 0, 1));
        vecs.push_back(mk(8'hE1, 1, 8'hE1, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(8'h14, 0, 8'h00, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(8'h77, 0, 8'h00, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(8'hE1, 0, 8'h00, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(8'h14, 0, 8'h00, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(8'h77, 0, 8'h00, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 8'h41, 0, 1));
        vecs.push_back(mk(8'h5A, 1, 8'h5A, 0, 0, 8'h0D, 0, 1));
        vecs.push_back(mk(8'h66, 1, 8'h66, 0, 0, 8'h08, 0, 1));
        vecs.push_back(mk(8'h59, 1, 8'h59, 0, 0, 8'h00, 1, 1));
        vecs.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 1, 1));
        vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 8'h00, 1, 1));
        vecs.push_back(mk(8'h59, 1, 8'h59, 0, 1, 8'h00, 0, 1));

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("reset ev_valid", ev_valid, 1'b0);
        chk("reset fifo_count", fifo_count, 3'd0);
        chk("reset ev_code", ev_code, 8'h00);
        chk("reset ev_ascii", ev_ascii, 8'h00);
        chk("reset overflow", overflow, 1'b0);
        chk("reset shift", shift_active, 1'b0);
        chk("reset caps", caps_lock, 1'b0);
        rst = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("row%0d", i);
            send_chk(tag, vecs[i].b, vecs[i].v, vecs[i].code, vecs[i].ext,
                     vecs[i].brk, vecs[i].asc);
            chk({tag, " shift"}, shift_active, vecs[i].sh);
            chk({tag, " caps"}, caps_lock, vecs[i].caps);
        end

        // ---------------- overflow and back-pressure ----------------
        ev_ready = 1'b0;
        tick(8'h15);
        tick(8'h1D);
        tick(8'h24);
        tick(8'h2D);
        chk("full count", fifo_count, 3'd4);
        chk("full no overflow yet", overflow, 1'b0);
        tick(8'h2C);
        $display("overflow push -> count %0d overflow %0d head %h",
                 fifo_count, overflow, ev_code);
        chk("ovf count", fifo_count, 3'd4);
        chk("ovf flag", overflow, 1'b1);
        repeat (3) @(negedge clk);
        chk("hold valid", ev_valid, 1'b1);
        chk("hold code", ev_code, 8'h15);

        // Full FIFO: pop and push in the same cycle.
        @(negedge clk);
        ev_ready     = 1'b1;
        rx_dout      = 8'h35;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        ev_ready     = 1'b0;
        chk("pop+push count", fifo_count, 3'd4);
        chk("pop+push head", ev_code, 8'h1D);

        pop_exp[0] = 8'h1D; pop_exp[1] = 8'h24;
        pop_exp[2] = 8'h2D; pop_exp[3] = 8'h35;
        for (int i = 0; i < 4; i++) begin
            $display("pop %0d -> valid %0d code %h", i, ev_valid, ev_code);
            chk($sformatf("pop%0d valid", i), ev_valid, 1'b1);
            chk($sformatf("pop%0d code", i), ev_code, pop_exp[i]);
            ev_ready = 1'b1;
            @(negedge clk);
            ev_ready = 1'b0;
        end
        chk("drained count", fifo_count, 3'd0);
        chk("drained valid", ev_valid, 1'b0);
        chk("overflow sticky", overflow, 1'b1);
        ev_ready = 1'b1;

        // ---------------- reset mid-prefix ----------------
        tick(8'hE0);
        #2 rst = 1'b1;
        #1;
        chk("async rst overflow", overflow, 1'b0);
        chk("async rst caps", caps_lock, 1'b0);
        tick(8'h1C);   // ignored while in reset
        @(negedge clk);
        rst = 1'b0;
        chk("rst tick ignored", ev_valid, 1'b0);
        send_chk("after E0 rst", 8'h1C, 1, 8'h1C, 0, 0, 8'h61);

        // ---------------- reset mid-SKIP_E1 ----------------
        send_chk("E1 start", 8'hE1, 1, 8'hE1, 0, 0, 8'h00);
        send_chk("E1 skip", 8'h14, 0, 8'h00, 0, 0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_chk("after E1 rst", 8'h1C, 1, 8'h1C, 0, 0, 8'h61);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
